time_set_controller: RTL
========================

Name: time_set_controller

Overview:
- Time-setting sequencer for the electronic clock.
- Takes the three debounced key levels (set, change-field, add) and runs a mode FSM: RUN → SET_HOUR → SET_MINUTE → SET_SECOND.
- Drives the counter's run enable, the field-select flags (which also feed the flashing indicators) and single-cycle increment pulses.
- Adds auto-repeat on a held add key and an inactivity timeout that returns to RUN.

Parameters:
- TIMEOUT_CYCLES, 500_000_000: clock cycles without any key rising edge in a SET state before forced return to RUN. Bench uses 20.
- REPEAT_DELAY_CYCLES, 25_000_000: continuous add-key hold, counted from the initial pulse, before the first auto-repeat pulse. Bench uses 8.
- REPEAT_RATE_CYCLES, 5_000_000: period between subsequent auto-repeat pulses. Bench uses 3.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-low reset
- set_time_key  input  1  debounced level, 1 = pressed
- set_time_change_key  input  1  debounced level, 1 = pressed
- set_time_add_key  input  1  debounced level, 1 = pressed
- run_en  output  1  1 = counter advances time; 0 = counter frozen for setting
- set_hour  output  1  hour field selected
- set_minute  output  1  minute field selected
- set_second  output  1  second field selected
- inc_hour  output  1  one-cycle pulse: hour +1 (counter wraps 23→00)
- inc_minute  output  1  one-cycle pulse: minute +1 (wraps 59→00, no carry)
- inc_second  output  1  one-cycle pulse: second +1 (wraps 59→00, no carry)
- mode  output  2  00 RUN, 01 SET_HOUR, 10 SET_MINUTE, 11 SET_SECOND

Behaviour:
- Reset (rst=0 at a clk edge):
  - mode=RUN, run_en=1.
  - All set_* and inc_* outputs = 0.
  - Timeout counter and repeat counters = 0.
  - Key-delay registers = 1, so a key held through reset produces no edge. It must be released and pressed again.
- Reset mid-setting: immediate RUN; any in-progress repeat is cancelled.
- Edge detect: rise = key & ~key_d, with key_d registered every cycle. The resulting state change or pulse is registered, so outputs update on the clk edge after the cycle in which the rise is seen (latency 1).
- All outputs are registered.
- Output decode:
  - set_hour/set_minute/set_second are one-hot in SET states and all 0 in RUN.
  - run_en = (mode==RUN).
  - At most one inc_* is high in any cycle, and only while in a SET state.
- Transitions:
  - RUN: set rise → SET_HOUR. Change/add rises are ignored.
  - SET_x: set rise → RUN.
  - SET_x: change rise → next field (HOUR→MINUTE→SECOND→HOUR).
  - SET_x: add rise → inc pulse for the current field.
  - SET_x: timeout → RUN.
- Simultaneous rises in one cycle: set beats change, change beats add. Lower-priority events that cycle are dropped.
- Auto-repeat:
  - An add rise issues one pulse and starts a hold counter.
  - While add stays 1 and the field is unchanged, the first repeat pulse comes REPEAT_DELAY_CYCLES after the initial pulse. Later pulses come every REPEAT_RATE_CYCLES.
  - Add release clears the repeat state.
  - A field change or exit with add held clears the repeat state. Add must then be released and re-pressed to pulse again.
- Timeout:
  - The counter runs only in SET states.
  - It clears on entering a SET state, on any key rise, and on every inc pulse (auto-repeat included).
  - On reaching TIMEOUT_CYCLES with no clearing event → RUN next edge; all set_* drop and run_en rises together.
  - A clearing event in the same cycle as the timeout wins: no exit.
- Counter widths are $clog2(param+1). They saturate and never wrap.

Test Plan:
- Reset with set_time_key held, release rst, keep key high 10 cycles → mode stays 00, run_en=1, no outputs change. Release and press again → mode=01, set_hour=1, run_en=0 one cycle after the rise.
- From SET_HOUR, press change three times → mode 10, 11, 01 in sequence with matching one-hot set_*. Press set → mode=00, all set_*=0.
- In SET_MINUTE, hold add 20 cycles (DELAY=8, RATE=3) → inc_minute pulses at offsets 1, 9, 12, 15, 18 after the rise, each 1 cycle wide. Release → no further pulses.
- In SET_SECOND, no key activity → exactly 20 cycles after entry, mode=00 and run_en=1. An inc pulse at cycle 19 instead restarts the 20-cycle count.
- In SET_HOUR, set and add rise in the same cycle → mode=00, no inc_hour. Change and add rise together → mode=10, no inc pulse.
- Hold add in SET_HOUR, press change while still holding → mode=10, no inc_minute until add is released and re-pressed; then exactly one inc_minute.

Source files
------------

// File: rtl/time_set_controller.sv
// Time-setting sequencer for the electronic clock.
// Turns the set / change-field / add key levels into a RUN/SET_x mode FSM,
// field-select flags, one-cycle increment pulses with add-key auto-repeat,
// and an inactivity timeout that drops back to RUN.
module time_set_controller #(
  parameter int unsigned TIMEOUT_CYCLES      = 500_000_000,
  parameter int unsigned REPEAT_DELAY_CYCLES = 25_000_000,
  parameter int unsigned REPEAT_RATE_CYCLES  = 5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_time_key,
  input  logic       set_time_change_key,
  input  logic       set_time_add_key,
  output logic       run_en,
  output logic       set_hour,
  output logic       set_minute,
  output logic       set_second,
  output logic       inc_hour,
  output logic       inc_minute,
  output logic       inc_second,
  output logic [1:0] mode
);

  localparam int unsigned REP_MAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                                    REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = $clog2(REP_MAX + 1);

  // The exit fires on the edge where the count would reach TIMEOUT_CYCLES,
  // so RUN is visible exactly TIMEOUT_CYCLES cycles after the last clear.
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TO_SAT  = TW'(TIMEOUT_CYCLES);
  localparam logic [RW-1:0] RP_DLY  = RW'(REPEAT_DELAY_CYCLES);
  localparam logic [RW-1:0] RP_RATE = RW'(REPEAT_RATE_CYCLES);
  localparam logic [RW-1:0] RP_SAT  = RW'(REP_MAX);
  localparam logic [RW-1:0] RP_ONE  = RW'(1);

  typedef enum logic [1:0] {
    M_RUN  = 2'b00,
    M_HOUR = 2'b01,
    M_MIN  = 2'b10,
    M_SEC  = 2'b11
  } mode_e;

  mode_e          mode_q, mode_d, nxt_field;
  logic [2:0]     key_d_q;
  logic [TW-1:0]  to_cnt_q, to_cnt_d;
  logic [RW-1:0]  rep_cnt_q, rep_cnt_d;
  logic           rep_act_q, rep_act_d;
  logic           rep_first_q, rep_first_d;
  logic           pulse_d;
  logic           set_rise, chg_rise, add_rise, rep_due;

  assign set_rise = set_time_key        & ~key_d_q[2];
  assign chg_rise = set_time_change_key & ~key_d_q[1];
  assign add_rise = set_time_add_key    & ~key_d_q[0];
  assign rep_due  = (rep_cnt_q == (rep_first_q ? RP_DLY : RP_RATE));
  assign mode     = mode_q;

  // Field rotation for the change key: HOUR -> MINUTE -> SECOND -> HOUR.
  always_comb begin
    nxt_field = M_HOUR;
    case (mode_q)
      M_HOUR:  nxt_field = M_MIN;
      M_MIN:   nxt_field = M_SEC;
      default: nxt_field = M_HOUR;
    endcase
  end

  // Next-state: prioritised key events, auto-repeat and timeout.
  always_comb begin
    mode_d      = mode_q;
    to_cnt_d    = to_cnt_q;
    rep_act_d   = rep_act_q;
    rep_first_d = rep_first_q;
    rep_cnt_d   = rep_cnt_q;
    pulse_d     = 1'b0;
    if (mode_q == M_RUN) begin
      to_cnt_d    = '0;
      rep_act_d   = 1'b0;
      rep_first_d = 1'b0;
      rep_cnt_d   = '0;
      if (set_rise) mode_d = M_HOUR;
    end else if (set_rise) begin
      mode_d      = M_RUN;
      to_cnt_d    = '0;
      rep_act_d   = 1'b0;
      rep_first_d = 1'b0;
      rep_cnt_d   = '0;
    end else if (chg_rise) begin
      // A held add key stays dead after a field change until re-pressed.
      mode_d      = nxt_field;
      to_cnt_d    = '0;
      rep_act_d   = 1'b0;
      rep_first_d = 1'b0;
      rep_cnt_d   = '0;
    end else if (add_rise) begin
      pulse_d     = 1'b1;
      to_cnt_d    = '0;
      rep_act_d   = 1'b1;
      rep_first_d = 1'b1;
      rep_cnt_d   = RP_ONE;
    end else if (rep_act_q && set_time_add_key && rep_due) begin
      pulse_d     = 1'b1;
      to_cnt_d    = '0;
      rep_first_d = 1'b0;
      rep_cnt_d   = RP_ONE;
    end else if (to_cnt_q == TO_LAST) begin
      mode_d      = M_RUN;
      to_cnt_d    = '0;
      rep_act_d   = 1'b0;
      rep_first_d = 1'b0;
      rep_cnt_d   = '0;
    end else begin
      if (to_cnt_q != TO_SAT) to_cnt_d = to_cnt_q + 1'b1;
      if (!set_time_add_key) begin
        rep_act_d   = 1'b0;
        rep_first_d = 1'b0;
        rep_cnt_d   = '0;
      end else if (rep_act_q && rep_cnt_q != RP_SAT) begin
        rep_cnt_d = rep_cnt_q + 1'b1;
      end
    end
  end

  // State and registered outputs; key delays reset high so held keys need a re-press.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_q      <= M_RUN;
      key_d_q     <= 3'b111;
      to_cnt_q    <= '0;
      rep_cnt_q   <= '0;
      rep_act_q   <= 1'b0;
      rep_first_q <= 1'b0;
      run_en      <= 1'b1;
      set_hour    <= 1'b0;
      set_minute  <= 1'b0;
      set_second  <= 1'b0;
      inc_hour    <= 1'b0;
      inc_minute  <= 1'b0;
      inc_second  <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      key_d_q     <= {set_time_key, set_time_change_key, set_time_add_key};
      to_cnt_q    <= to_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      rep_act_q   <= rep_act_d;
      rep_first_q <= rep_first_d;
      run_en      <= (mode_d == M_RUN);
      set_hour    <= (mode_d == M_HOUR);
      set_minute  <= (mode_d == M_MIN);
      set_second  <= (mode_d == M_SEC);
      inc_hour    <= pulse_d && (mode_q == M_HOUR);
      inc_minute  <= pulse_d && (mode_q == M_MIN);
      inc_second  <= pulse_d && (mode_q == M_SEC);
    end
  end

endmodule
